// File: rtl/encoder8to3_pkg.sv
// Shared sizes and FSM state type for the sticky 8-to-3 request encoder.
package encoder8to3_pkg;
    localparam int NUM_REQ = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/encoder8to3_sticky_prio_pick8.sv
// Combinational picker: first set bit of vec searching downward from start, with wrap.
module prio_pick8
    import encoder8to3_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    input  logic [CODE_W-1:0]  start,
    output logic               found,
    output logic [CODE_W-1:0]  index,
    output logic [NUM_REQ-1:0] onehot
);
    logic [CODE_W-1:0] pos;

    always_comb begin
        found  = 1'b0;
        index  = start;
        onehot = '0;
        pos    = '0;
        // Modulo-8 subtraction gives the wrap from 0 back to 7 for free.
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = start - CODE_W'(k);
            if (!found && vec[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
        if (found) onehot = NUM_REQ'(1) << index;
    end
endmodule

// File: rtl/encoder8to3_sticky.sv
// Sticky request encoder: captures request pulses, grants one code per cycle via valid/ready.
// Define ENCODER8TO3_RR_EN for round-robin selection instead of fixed priority (7 highest).
module encoder8to3_sticky
    import encoder8to3_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [CODE_W-1:0]  out_code,
    output logic [NUM_REQ-1:0] pend,
    output logic               overflow
);
    state_t              state, state_next;
    logic [CODE_W-1:0]   start;
    logic                found;
    logic [CODE_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0]  pick_oh;
    logic                load;
    logic [NUM_REQ-1:0]  clr;
    logic [NUM_REQ-1:0]  set_vec;

`ifdef ENCODER8TO3_RR_EN
    logic [CODE_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= CODE_W'(NUM_REQ - 1);
        else if (load) ptr <= pick_idx - CODE_W'(1);
    end

    assign start = ptr;
`else
    assign start = CODE_W'(NUM_REQ - 1);
`endif

    // Selection only ever looks at registered pend, never at same-cycle req.
    prio_pick8 u_pick (
        .vec    (pend),
        .start  (start),
        .found  (found),
        .index  (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: if (found) begin
                load       = 1'b1;
                state_next = HOLD;
            end
            HOLD: if (out_ready) begin
                if (found) load = 1'b1;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign clr     = load ? pick_oh : '0;
    assign set_vec = ena ? req : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            out_code <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            pend     <= (pend & ~clr) | set_vec;
            overflow <= |(set_vec & pend & ~clr);
            if (load) out_code <= pick_idx;
        end
    end

    assign out_valid = (state == HOLD);
endmodule

// File: tb/tb_encoder8to3_sticky.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a model.
module tb_encoder8to3_sticky;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] pend;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    encoder8to3_sticky dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pend      (pend),
        .overflow  (overflow)
    );

    // Behavioural model: a set of pending indices, a held grant, and a search pointer.
    bit         m_pend [8];
    bit         m_valid;
    int         m_code;
    int         m_ptr;
    bit         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_pend[i] <= 1'b0;
            m_valid <= 1'b0;
            m_code  <= 0;
            m_ptr   <= 7;
            m_ovf   <= 1'b0;
        end else begin
            automatic int  any = 0;
            automatic int  g   = -1;
            automatic int  st;
            automatic bit  grant;
            automatic bit  ov  = 1'b0;
            for (int i = 0; i < 8; i++) any += m_pend[i];
`ifdef ENCODER8TO3_RR_EN
            st = m_ptr;
`else
            st = 7;
`endif
            grant = (any > 0) && (!m_valid || out_ready);
            if (grant) begin
                for (int k = 0; k < 8; k++)
                    if (g < 0 && m_pend[(st - k + 8) % 8]) g = (st - k + 8) % 8;
            end
            for (int i = 0; i < 8; i++) begin
                automatic bit cleared = grant && (i == g);
                automatic bit newreq  = ena && req[i];
                if (newreq && m_pend[i] && !cleared) ov = 1'b1;
                m_pend[i] <= (m_pend[i] && !cleared) || newreq;
            end
            m_ovf <= ov;
            if (grant) begin
                m_valid <= 1'b1;
                m_code  <= g;
                m_ptr   <= (g + 7) % 8;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] model_pend();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    always @(negedge clk) begin
        automatic logic [7:0] mp = model_pend();
        tests++;
        if (out_valid !== m_valid || pend !== mp || overflow !== m_ovf ||
            out_code !== 3'(m_code)) begin
            fails++;
            $display("FAIL model t=%0t: got valid=%0b code=%0d pend=%02h ovf=%0b, expected valid=%0b code=%0d pend=%02h ovf=%0b",
                     $time, out_valid, out_code, pend, overflow, m_valid, m_code, mp, m_ovf);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, then advance to the next falling edge (one rising edge consumed).
    task automatic drive(input logic e, input logic [7:0] r, input logic rd);
        ena = e; req = r; out_ready = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; req = '0; out_ready = 1'b0;
        #1;
        chk("reset_valid", 8'(out_valid), 8'h00);
        chk("reset_pend", pend, 8'h00);
        chk("reset_code", 8'(out_code), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h00, 1'b1);
            chk("idle_valid", 8'(out_valid), 8'h00);
            chk("idle_pend", pend, 8'h00);
            chk("idle_ovf", 8'(overflow), 8'h00);
        end

        // One pulse of 1000_0101 drains as 7, 2, 0.
        drive(1'b1, 8'h85, 1'b1);
        chk("cap_pend", pend, 8'h85);
        chk("cap_valid", 8'(out_valid), 8'h00);
        drive(1'b0, 8'h00, 1'b1); chk("seq_a", 8'(out_code), 8'd7); chk("seq_a_pend", pend, 8'h05);
        drive(1'b0, 8'h00, 1'b1); chk("seq_b", 8'(out_code), 8'd2);
        drive(1'b0, 8'h00, 1'b1); chk("seq_c", 8'(out_code), 8'd0); chk("seq_c_v", 8'(out_valid), 8'h01);
        drive(1'b0, 8'h00, 1'b1); chk("seq_idle", 8'(out_valid), 8'h00); chk("seq_hold_code", 8'(out_code), 8'd0);

`ifdef ENCODER8TO3_RR_EN
        // Grant 1 leaves ptr at 0, so the same pulse drains as 0, 7, 2.
        drive(1'b1, 8'h02, 1'b1);
        drive(1'b0, 8'h00, 1'b1); chk("rr_pre", 8'(out_code), 8'd1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h85, 1'b1);
        drive(1'b0, 8'h00, 1'b1); chk("rr_a", 8'(out_code), 8'd0);
        drive(1'b0, 8'h00, 1'b1); chk("rr_b", 8'(out_code), 8'd7);
        drive(1'b0, 8'h00, 1'b1); chk("rr_c", 8'(out_code), 8'd2);
        drive(1'b0, 8'h00, 1'b1);
`endif

        // Held code 3 under backpressure; re-request of 3 twice.
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b0, 8'h00, 1'b0); chk("bp_code", 8'(out_code), 8'd3); chk("bp_pend0", pend, 8'h00);
        drive(1'b1, 8'h08, 1'b0); chk("bp_pend1", pend, 8'h08); chk("bp_ovf0", 8'(overflow), 8'h00);
        drive(1'b1, 8'h08, 1'b0); chk("bp_ovf1", 8'(overflow), 8'h01); chk("bp_code2", 8'(out_code), 8'd3);
        drive(1'b0, 8'h00, 1'b0); chk("bp_ovf_pulse", 8'(overflow), 8'h00); chk("bp_code3", 8'(out_code), 8'd3);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1); chk("bp_done", 8'(out_valid), 8'h00);

        // ena=0 blocks captures but pending bits still drain.
        drive(1'b1, 8'h21, 1'b0); chk("en_pend", pend, 8'h21);
        drive(1'b0, 8'hFF, 1'b0); chk("en_code", 8'(out_code), 8'd5); chk("en_pend1", pend, 8'h01);
        drive(1'b0, 8'hFF, 1'b0); chk("en_pend2", pend, 8'h01); chk("en_ovf", 8'(overflow), 8'h00);
        drive(1'b0, 8'h00, 1'b1); chk("en_code0", 8'(out_code), 8'd0);
        drive(1'b0, 8'h00, 1'b1);

        // Asynchronous reset while holding with pend=30.
        drive(1'b1, 8'h70, 1'b0);
        drive(1'b0, 8'h00, 1'b0); chk("ar_pend", pend, 8'h30); chk("ar_valid", 8'(out_valid), 8'h01);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid0", 8'(out_valid), 8'h00);
        chk("ar_pend0", pend, 8'h00);
        chk("ar_code0", 8'(out_code), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("ar_nogrant", 8'(out_valid), 8'h00);
        end

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, 8'($urandom & $urandom & $urandom),
                  $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/encoder8to3_sticky.md
ENCODER8TO3_STICKY -- requirements
Module: encoder8to3_sticky

Interface
REQ-001 SHALL have no parameters; the block has 8 request inputs and a 3-bit code.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  capture enable for req; 0 blocks new captures only.
REQ-005 req  input  8  request pulses; bit i requests code i.
REQ-006 out_ready  input  1  consumer accepts out_code when high with out_valid.
REQ-007 out_valid  output  1  out_code holds a granted request.
REQ-008 out_code  output  3  index of granted request.
REQ-009 pend  output  8  pending (captured, not yet granted) requests.
REQ-010 overflow  output  1  one-cycle pulse: a request hit an already-pending bit.

Function
REQ-011 SHALL update the pending register each edge as pend_next = (pend & ~clr) | (ena ? req : 8'h00), with clr = one-hot of the bit loaded into the output that edge.
REQ-012 SHALL let a set win over a clear when req[i] and clr[i] coincide, so bit i stays pending.
REQ-013 SHALL run a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-014 IDLE with pend!=0 SHALL load the selected index into out_code, clear it from pend, and go to HOLD.
REQ-015 HOLD with out_ready=0 SHALL keep out_code and out_valid stable.
REQ-016 HOLD with out_ready=1 and pend!=0 SHALL reload the next selection that same edge, giving one grant per cycle back-to-back.
REQ-017 HOLD with out_ready=1 and pend==0 SHALL go to IDLE.
REQ-018 Selection SHALL use only the registered pend, never same-cycle req. A req sampled at edge k SHALL set pend after edge k; out_valid SHALL rise no earlier than edge k+1.
REQ-019 Default selection SHALL be fixed priority, with index 7 highest and index 0 lowest.
REQ-020 overflow SHALL be registered and assert for one cycle after an edge where ena=1, req[i]=1, pend[i]=1 and clr[i]=0 for any i.
REQ-021 With ena=0, pending requests SHALL still drain through the output normally.
REQ-022 out_code SHALL be held at its last value while IDLE.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, force: pend=8'h00, state IDLE, out_valid=0, out_code=3'd0, overflow=0, round-robin pointer=7.
REQ-024 Reset mid-transaction SHALL discard the held code and all pending requests.
REQ-025 Deassertion SHALL take effect at the next rising clk; the first capture SHALL occur no earlier than that edge.

Configuration
REQ-026 Defining macro ENCODER8TO3_RR_EN SHALL compile in round-robin selection.
REQ-027 In round-robin mode, the search SHALL start at pointer ptr and go downward with wrap (ptr, ptr-1, ..., 0, 7, ...).
REQ-028 After granting index g, ptr SHALL become (g-1) mod 8.
REQ-029 ptr SHALL be unchanged when no grant occurs.
REQ-030 Without the macro, selection SHALL be fixed priority per REQ-019, and no pointer register SHALL exist.

Structure
REQ-031 Package encoder8to3_pkg SHALL hold NUM_REQ=8, CODE_W=3, and the FSM state enum (IDLE, HOLD).
REQ-032 SHALL contain one combinational sub-module, prio_pick8.
REQ-033 prio_pick8 SHALL take an 8-bit vector and a 3-bit start index, and return found, index and one-hot.
REQ-034 Fixed mode SHALL tie the prio_pick8 start index to 7.

Verification
REQ-035 Reset, then req=8'h00 for 5 cycles -> out_valid=0, pend=8'h00, overflow=0 throughout.
REQ-036 ena=1, req=8'b1000_0101 for one cycle, out_ready=1 -> codes 7, 2, 0 on consecutive cycles, then IDLE.
REQ-037 Same stimulus with RR_EN, run after an earlier grant of 1 (ptr=0) -> codes 0, 7, 2.
REQ-038 out_ready=0 with code 3 held; pulse req[3] twice -> code 3 stays stable; first pulse sets pend[3]; second pulse gives overflow=1 for one cycle.
REQ-039 ena=0, req=8'hFF -> pend unchanged, no overflow; pre-pending bit 5 still granted as code 5.
REQ-040 rst_n=0 asynchronously while HOLD with pend=8'h30 -> out_valid=0 and pend=8'h00 before the next edge; no grant after release until new req.
